// File: rtl/register_bank_16x20.sv
// Sixteen-entry 20-bit register bank with a writeback port, a PC increment path on r15,
// and a per-register pending scoreboard for multi-cycle results.
module register_bank_16x20 #(
    parameter logic [19:0] PC_RESET = 20'h00000,
    parameter logic [19:0] PC_STEP  = 20'h00001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [19:0] wdata,
    input  logic        inc_en,
    input  logic        claim,
    input  logic [3:0]  claim_addr,
    input  logic [3:0]  chk_addr,
    output logic        hazard,
    output logic [15:0] pending,
    output logic [19:0] q0,
    output logic [19:0] q1,
    output logic [19:0] q2,
    output logic [19:0] q3,
    output logic [19:0] q4,
    output logic [19:0] q5,
    output logic [19:0] q6,
    output logic [19:0] q7,
    output logic [19:0] q8,
    output logic [19:0] q9,
    output logic [19:0] q10,
    output logic [19:0] q11,
    output logic [19:0] q12,
    output logic [19:0] q13,
    output logic [19:0] q14,
    output logic [19:0] q15
);

    logic [19:0] regs_r    [16];
    logic [19:0] regs_next_s [16];
    logic [15:0] pending_r;
    logic [15:0] pending_next_s;

    // Register next-state: writeback beats the PC increment on r15.
    always_comb begin
        regs_next_s = regs_r;
        for (int i = 0; i < 16; i++) begin
            if (we && (waddr == 4'(i))) begin
                regs_next_s[i] = wdata;
            end else if ((i == 15) && inc_en) begin
                regs_next_s[i] = regs_r[i] + PC_STEP;
            end else begin
                regs_next_s[i] = regs_r[i];
            end
        end
    end

    // Scoreboard next-state: a claim beats a same-cycle writeback to the same register.
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < 16; i++) begin
            if (claim && (claim_addr == 4'(i))) begin
                pending_next_s[i] = 1'b1;
            end else if (we && (waddr == 4'(i))) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
    end

    // Bank and scoreboard state; reset aborts any in-flight update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_r[i] <= 20'h00000;
            end
            regs_r[15] <= PC_RESET;
            pending_r  <= 16'h0000;
        end else begin
            regs_r    <= regs_next_s;
            pending_r <= pending_next_s;
        end
    end

    // Hazard looks only at registered scoreboard state, never at same-cycle claim/we.
    assign hazard  = pending_r[chk_addr];
    assign pending = pending_r;

    assign q0  = regs_r[0];
    assign q1  = regs_r[1];
    assign q2  = regs_r[2];
    assign q3  = regs_r[3];
    assign q4  = regs_r[4];
    assign q5  = regs_r[5];
    assign q6  = regs_r[6];
    assign q7  = regs_r[7];
    assign q8  = regs_r[8];
    assign q9  = regs_r[9];
    assign q10 = regs_r[10];
    assign q11 = regs_r[11];
    assign q12 = regs_r[12];
    assign q13 = regs_r[13];
    assign q14 = regs_r[14];
    assign q15 = regs_r[15];

endmodule
